instr_fetch_unit: RTL and testbench

//  Fetch stage feeding the MIPS core's decode/control path. Owns the PC, issues word reads to instruction memory,

---
 rtl/instr_fetch_unit.sv | 176 +++++++++++++++++
 tb/tb_instr_fetch_unit.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: MIPS fetch stage. Owns the fetch PC, issues word reads to
// instruction memory under a credit rule, buffers in-order responses in a small
// prefetch FIFO and hands instruction/pc/pc+4 to decode over valid/ready.
// Redirects flush buffered words and drain in-flight wrong-path responses.
// Optional feature macro: IF_PERF_CNT_EN adds perf_fetched / perf_flushed counters.
//
// state | meaning
// IDLE  | first cycle after reset, no requests
// FETCH | issuing requests while credit allows, pushing responses
// DRAIN | discarding stale responses left over from a redirect
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc4
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_flushed
`endif
);

  localparam int          PW         = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int          CW         = PW + 1;
  localparam logic [31:0] RESET_PC_A = {RESET_PC[31:2], 2'b00};
  localparam logic [CW:0] DEPTH_C    = FIFO_DEPTH[CW:0];

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN} state_t;

  state_t          r_state, w_state_nxt;
  logic [31:0]     r_fetch_pc, w_fetch_pc_nxt;
  logic [31:0]     r_rsp_pc, w_rsp_pc_nxt;
  logic [CW-1:0]   r_outstanding, w_outstanding_nxt;
  logic [CW-1:0]   r_drop, w_drop_nxt;
  logic [CW-1:0]   r_count;
  logic [PW-1:0]   r_rd_ptr, r_wr_ptr;
  logic [31:0]     r_fifo_instr [FIFO_DEPTH];
  logic [31:0]     r_fifo_pc    [FIFO_DEPTH];
  logic            w_issue, w_rsp, w_pop, w_push, w_flush, w_drop_rsp;
  logic [CW:0]     w_credit_used;
  logic [31:0]     w_redirect_pc;

  // A pop this cycle frees its entry for credit purposes, which is what lets a
  // one-cycle memory sustain one instruction per cycle.
  assign w_redirect_pc     = {redirect_pc[31:2], 2'b00};
  assign w_pop             = if_valid && if_ready;
  assign w_rsp             = imem_rvalid && (r_outstanding != '0);
  assign w_credit_used     = {1'b0, r_count} - (CW+1)'(w_pop) + {1'b0, r_outstanding};
  assign imem_req          = (r_state == S_FETCH) && (w_credit_used < DEPTH_C);
  assign imem_addr         = r_fetch_pc;
  assign w_issue           = imem_req && imem_gnt;
  assign w_outstanding_nxt = r_outstanding + CW'(w_issue) - CW'(w_rsp);

  assign if_valid = (r_count != '0);
  assign if_instr = if_valid ? r_fifo_instr[r_rd_ptr] : 32'd0;
  assign if_pc    = if_valid ? r_fifo_pc[r_rd_ptr] : 32'd0;
  assign if_pc4   = if_valid ? (r_fifo_pc[r_rd_ptr] + 32'd4) : 32'd0;

  // Next-state, PC and drop-count decisions.
  always_comb begin
    w_state_nxt    = r_state;
    w_fetch_pc_nxt = r_fetch_pc;
    w_rsp_pc_nxt   = r_rsp_pc;
    w_drop_nxt     = r_drop;
    w_push         = 1'b0;
    w_flush        = 1'b0;
    w_drop_rsp     = 1'b0;
    unique case (r_state)
      S_IDLE: w_state_nxt = S_FETCH;
      S_FETCH: begin
        if (redirect) begin
          // Same-cycle issue becomes stale; same-cycle response is discarded.
          w_fetch_pc_nxt = w_redirect_pc;
          w_rsp_pc_nxt   = w_redirect_pc;
          w_flush        = 1'b1;
          w_drop_rsp     = w_rsp;
          w_drop_nxt     = w_outstanding_nxt;
          if (w_outstanding_nxt != '0) w_state_nxt = S_DRAIN;
        end else begin
          if (w_issue) w_fetch_pc_nxt = r_fetch_pc + 32'd4;
          if (w_rsp) begin
            w_push       = 1'b1;
            w_rsp_pc_nxt = r_rsp_pc + 32'd4;
          end
        end
      end
      S_DRAIN: begin
        w_drop_rsp = w_rsp;
        if (w_rsp) w_drop_nxt = r_drop - CW'(1);
        if (redirect) begin
          w_fetch_pc_nxt = w_redirect_pc;
          w_rsp_pc_nxt   = w_redirect_pc;
        end
        if ((r_drop == '0) || (w_rsp && (r_drop == CW'(1)))) w_state_nxt = S_FETCH;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_fetch_pc    <= RESET_PC_A;
      r_rsp_pc      <= RESET_PC_A;
      r_outstanding <= '0;
      r_drop        <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_fetch_pc    <= w_fetch_pc_nxt;
      r_rsp_pc      <= w_rsp_pc_nxt;
      r_outstanding <= w_outstanding_nxt;
      r_drop        <= w_drop_nxt;
    end
  end

  // FIFO pointers and occupancy; a flush empties the buffer outright.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (w_flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  // FIFO storage; contents are masked at the outputs while empty, so no reset.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_instr[r_wr_ptr] <= imem_rdata;
      r_fifo_pc[r_wr_ptr]    <= r_rsp_pc;
    end
  end

`ifdef IF_PERF_CNT_EN
  logic [31:0] r_perf_fetched, r_perf_flushed;
  logic [31:0] w_flush_cnt;

  // Entries popped on the redirect cycle count as consumed, not flushed.
  assign w_flush_cnt  = w_flush ? (32'(r_count) - 32'(w_pop)) : 32'd0;
  assign perf_fetched = r_perf_fetched;
  assign perf_flushed = r_perf_flushed;

  // Performance counters, free-running with natural wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_fetched <= 32'd0;
      r_perf_flushed <= 32'd0;
    end else begin
      r_perf_fetched <= r_perf_fetched + 32'(w_pop);
      r_perf_flushed <= r_perf_flushed + w_flush_cnt + 32'(w_drop_rsp);
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: randomized bench for instr_fetch_unit with a
// transaction-level memory and fetch-stream model.
module tb_instr_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req, imem_gnt, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        if_valid, if_ready;
  logic [31:0] if_instr, if_pc, if_pc4;
`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_fetched, perf_flushed;
`endif

  instr_fetch_unit #(.RESET_PC(RESET_PC), .FIFO_DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .if_valid    (if_valid),
    .if_ready    (if_ready),
    .if_instr    (if_instr),
    .if_pc       (if_pc),
    .if_pc4      (if_pc4)
`ifdef IF_PERF_CNT_EN
    ,
    .perf_fetched(perf_fetched),
    .perf_flushed(perf_flushed)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
    bit          stale;
  } req_t;

  req_t        q[$];
  logic [31:0] issue_log[$];
  logic [31:0] pop_log[$];
  int          pop_cyc_log[$];

  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          m_buf;
  int          dropped = 0;
  int          pops = 0;
  bit          idle;
  logic [31:0] exp_pc, exp_addr, exp_fetched, exp_flushed;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC3A5_5A3C;
  endfunction

  function automatic logic [31:0] issue_at(input int i);
    return (i < issue_log.size()) ? issue_log[i] : 32'hxxxx_xxxx;
  endfunction

  function automatic logic [31:0] pop_at(input int i);
    return (i < pop_log.size()) ? pop_log[i] : 32'hxxxx_xxxx;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock: drive inputs at the falling edge, compare against the model,
  // advance the model as if the coming rising edge has happened.
  task automatic step(input bit rdy, input bit g, input bit rd, input logic [31:0] rpc,
                      input int lat);
    bit rv, pop, drain, req_exp;
    int credit;
    rv = (q.size() > 0) && (q[0].due <= cyc);
    imem_rvalid = rv;
    imem_rdata  = rv ? memf(q[0].addr) : $urandom;
    if_ready    = rdy;
    imem_gnt    = g;
    redirect    = rd;
    redirect_pc = rpc;
    #1;
    chk("if_valid", if_valid, (m_buf > 0));
    if (m_buf > 0) begin
      chk("if_pc", if_pc, exp_pc);
      chk("if_instr", if_instr, memf(exp_pc));
      chk("if_pc4", if_pc4, exp_pc + 32'd4);
    end
    pop     = (m_buf > 0) && rdy;
    drain   = (q.size() > 0) && q[0].stale;
    credit  = m_buf - (pop ? 1 : 0) + q.size();
    req_exp = !idle && !drain && (credit < DEPTH);
    chk("imem_req", imem_req, req_exp);
    if (imem_req) chk("imem_addr", imem_addr, exp_addr);
`ifdef IF_PERF_CNT_EN
    chk("perf_fetched", perf_fetched, exp_fetched);
    chk("perf_flushed", perf_flushed, exp_flushed);
`endif
    if (pop) begin
      pop_log.push_back(exp_pc);
      pop_cyc_log.push_back(cyc);
      exp_pc = exp_pc + 32'd4;
      m_buf--;
      pops++;
      exp_fetched = exp_fetched + 32'd1;
    end
    if (rv) begin
      if (q[0].stale || rd) begin
        dropped++;
        exp_flushed = exp_flushed + 32'd1;
      end else begin
        m_buf++;
      end
      void'(q.pop_front());
    end
    if (imem_req && g) begin
      issue_log.push_back(imem_addr);
      q.push_back('{addr: imem_addr, due: cyc + lat, stale: 1'b0});
      exp_addr = exp_addr + 32'd4;
    end
    if (rd) begin
      foreach (q[i]) q[i].stale = 1'b1;
      exp_flushed = exp_flushed + 32'(m_buf);
      m_buf    = 0;
      exp_pc   = {rpc[31:2], 2'b00};
      exp_addr = {rpc[31:2], 2'b00};
    end
    idle = 1'b0;
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  // Asynchronous reset asserted between edges; outputs must go to reset values at once.
  task automatic apply_reset();
    #2;
    rst_n       = 1'b0;
    imem_rvalid = 1'b0;
    imem_gnt    = 1'b0;
    redirect    = 1'b0;
    if_ready    = 1'b0;
    #1;
    chk("rst_req", imem_req, 1'b0);
    chk("rst_addr", imem_addr, RESET_PC);
    chk("rst_valid", if_valid, 1'b0);
    chk("rst_instr", if_instr, 32'd0);
    chk("rst_pc", if_pc, 32'd0);
    chk("rst_pc4", if_pc4, 32'd0);
`ifdef IF_PERF_CNT_EN
    chk("rst_perf_fetched", perf_fetched, 32'd0);
    chk("rst_perf_flushed", perf_flushed, 32'd0);
`endif
    q.delete();
    issue_log.delete();
    pop_log.delete();
    pop_cyc_log.delete();
    m_buf       = 0;
    exp_pc      = RESET_PC;
    exp_addr    = RESET_PC;
    exp_fetched = 32'd0;
    exp_flushed = 32'd0;
    idle        = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int d0, diff, rpops;
    logic [31:0] rpc;
    rst_n       = 1'b0;
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'd0;
    redirect    = 1'b0;
    redirect_pc = 32'd0;
    if_ready    = 1'b0;
    @(negedge clk);
    apply_reset();

    // Back-to-back streaming with a one-cycle memory.
    for (int i = 0; i < 12; i++) step(1, 1, 0, 32'd0, 1);
    chk("t1_addr0", issue_at(0), 32'h0);
    chk("t1_addr1", issue_at(1), 32'h4);
    chk("t1_addr2", issue_at(2), 32'h8);
    chk("t1_pop0", pop_at(0), 32'h0);
    chk("t1_pop1", pop_at(1), 32'h4);
    chk("t1_pop2", pop_at(2), 32'h8);
    diff = (pop_cyc_log.size() >= 3) ? (pop_cyc_log[2] - pop_cyc_log[0]) : -1;
    chk("t1_b2b", 32'(diff), 32'd2);

    // Reset in the middle of a burst with requests in flight.
    for (int i = 0; i < 5; i++) step(1, 1, 0, 32'd0, 3);
    apply_reset();

    // Decode stalled: buffer fills to depth, requests stop, head holds pc 0.
    for (int i = 0; i < 10; i++) step(0, 1, 0, 32'd0, 1);
    chk("t2_issues", 32'(issue_log.size()), 32'(DEPTH));
    chk("t2_req", imem_req, 1'b0);
    chk("t2_valid", if_valid, 1'b1);
    chk("t2_pc", if_pc, 32'h0);
    for (int i = 0; i < 5; i++) step(1, 1, 0, 32'd0, 1);
    chk("t2_pop0", pop_at(0), 32'h0);
    chk("t2_pop1", pop_at(1), 32'h4);

    // Redirect with two responses in flight on a three-cycle memory.
    apply_reset();
    for (int i = 0; i < 20 && !(q.size() == 2 && m_buf == 0); i++) step(1, 1, 0, 32'd0, 3);
    chk("t3_setup", 32'(q.size()), 32'd2);
    d0 = dropped;
    pop_log.delete();
    step(1, 1, 1, 32'h0000_0040, 3);
    for (int i = 0; i < 15; i++) step(1, 1, 0, 32'd0, 3);
    chk("t3_dropped", 32'(dropped - d0), 32'd2);
    chk("t3_first_pc", pop_at(0), 32'h40);

    // Unaligned redirect target, then address wrap at the top of memory.
    step(1, 1, 1, 32'h0000_0103, 1);
    issue_log.delete();
    for (int i = 0; i < 8; i++) step(1, 1, 0, 32'd0, 1);
    chk("t4_align", issue_at(0), 32'h100);
    step(1, 1, 1, 32'hFFFF_FFF8, 1);
    issue_log.delete();
    pop_log.delete();
    for (int i = 0; i < 10; i++) step(1, 1, 0, 32'd0, 1);
    chk("t4_wrap_a", issue_at(0), 32'hFFFF_FFF8);
    chk("t4_wrap_b", issue_at(1), 32'hFFFF_FFFC);
    chk("t4_wrap_c", issue_at(2), 32'h0000_0000);
    chk("t4_pop_wrap", pop_at(2), 32'h0000_0000);

    // Randomized traffic: stalls, grant gaps, variable latency, redirects.
    rpops = pops;
    for (int i = 0; i < 3000; i++) begin
      rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
      step(($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 19) == 0), rpc, $urandom_range(1, 4));
    end
    chk("rand_progress", 32'((pops - rpops) > 200), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
